// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the Avalon-MM on-chip RAM slave.
// Holds the sequencer state encoding, the read-latency legality check and the byte-parity helper.
package onchip_ram_pkg;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   function automatic bit rd_lat_legal(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   // Even parity: the stored bit makes the 9-bit group carry an even number of ones.
   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/onchip_ram_array.sv
// Single-port synchronous RAM with per-lane write enables, read enable and a global clock enable.
module onchip_ram_array
   import onchip_ram_pkg::*;
#(
   parameter int    LANES     = 4,
   parameter int    LANE_W    = 8,
   parameter int    DEPTH     = 16,
   parameter int    AW        = 4,
   parameter string INIT_FILE = ""
) (
   input  logic                    clk,
   input  logic                    i_ce,
   input  logic [LANES-1:0]        i_we,
   input  logic                    i_re,
   input  logic [AW-1:0]           i_addr,
   input  logic [LANES*LANE_W-1:0] i_wdata,
   output logic [LANES*LANE_W-1:0] o_rdata
);

   localparam int W = LANES * LANE_W;

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_ce) begin
         for (int i = 0; i < LANES; i++) begin
            if (i_we[i]) r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
         end
         if (i_re) r_q <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/onchip_ram_avmm.sv
// Avalon-MM on-chip RAM slave: post-reset clear sequencer, waitrequest flow control, 1/2-cycle read pipeline.
// Define ONCHIP_RAM_PARITY_EN to store an even-parity bit per byte and report read parity errors.
module onchip_ram_avmm
   import onchip_ram_pkg::*;
#(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    DEPTH          = 16384,
   parameter int                    READ_LATENCY   = 1,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
   parameter string                 INIT_FILE      = "",
   localparam int                   BE_WIDTH       = DATA_WIDTH / 8,
   localparam int                   ADDR_WIDTH     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [BE_WIDTH-1:0]   byteenable,
   input  logic                  chipselect,
   input  logic                  read,
   input  logic                  write,
   input  logic [DATA_WIDTH-1:0] writedata,
   input  logic                  clken,
   output logic [DATA_WIDTH-1:0] readdata,
   output logic                  readdatavalid,
   output logic                  waitrequest,
   output logic                  init_done,
   output logic                  parity_err
);

`ifdef ONCHIP_RAM_PARITY_EN
   localparam int LANE_W = 9;
`else
   localparam int LANE_W = 8;
`endif
   localparam int MEM_W = BE_WIDTH * LANE_W;

   generate
      if (!rd_lat_legal(READ_LATENCY)) begin : g_bad_lat
         $error("onchip_ram_avmm: READ_LATENCY must be 1 or 2");
      end
   endgenerate

   state_e                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
   logic                  w_clearing, w_wait, w_accept, w_in_rng, w_wr, w_rd, w_clr_we;
   logic [BE_WIDTH-1:0]   w_lane_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_wdata, w_rdata_raw, w_rdata_s1;
   logic [MEM_W-1:0]      w_mem_wdata, w_mem_rdata;
   logic                  r_vld1, r_ok1, r_vld2;
   logic [DATA_WIDTH-1:0] r_rdata2;

   assign w_clearing = (r_state == ST_CLEAR);
   assign w_wait     = w_clearing | ~clken;
   assign w_accept   = chipselect & (read | write) & ~w_wait;
   assign w_in_rng   = ({1'b0, address} < (ADDR_WIDTH+1)'(DEPTH));
   assign w_wr       = w_accept & write & w_in_rng;
   assign w_rd       = w_accept & read & ~write;
   assign w_clr_we   = w_clearing & (CLEAR_ON_RESET != 0);
   assign w_lane_we  = w_clr_we ? '1 : (w_wr ? byteenable : '0);
   assign w_mem_addr = w_clearing ? r_clr_addr : address;
   assign w_wdata    = w_clearing ? CLEAR_VALUE : writedata;

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      case (r_state)
         ST_CLEAR: begin
            if (clken) begin
               w_clr_addr_nxt = r_clr_addr + ADDR_WIDTH'(1);
               if ((CLEAR_ON_RESET == 0) || (r_clr_addr == ADDR_WIDTH'(DEPTH-1)))
                  w_state_nxt = ST_READY;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_CLEAR;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   // Each memory lane is {parity, byte} when parity is built in, else just the byte.
   always_comb begin
      w_mem_wdata = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
`ifdef ONCHIP_RAM_PARITY_EN
         w_mem_wdata[i*LANE_W +: LANE_W] = {byte_par(w_wdata[i*8 +: 8]), w_wdata[i*8 +: 8]};
`else
         w_mem_wdata[i*LANE_W +: LANE_W] = w_wdata[i*8 +: 8];
`endif
      end
   end

   onchip_ram_array #(
      .LANES     (BE_WIDTH),
      .LANE_W    (LANE_W),
      .DEPTH     (DEPTH),
      .AW        (ADDR_WIDTH),
      .INIT_FILE ((CLEAR_ON_RESET != 0) ? "" : INIT_FILE)
   ) u_array (
      .clk     (clk),
      .i_ce    (clken),
      .i_we    (w_lane_we),
      .i_re    (w_rd),
      .i_addr  (w_mem_addr),
      .i_wdata (w_mem_wdata),
      .o_rdata (w_mem_rdata)
   );

   always_comb begin
      w_rdata_raw = '0;
      for (int i = 0; i < BE_WIDTH; i++)
         w_rdata_raw[i*8 +: 8] = w_mem_rdata[i*LANE_W +: 8];
   end

   // Out-of-range reads still complete, but return zero.
   assign w_rdata_s1 = (r_vld1 & r_ok1) ? w_rdata_raw : '0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld1   <= 1'b0;
         r_ok1    <= 1'b0;
         r_vld2   <= 1'b0;
         r_rdata2 <= '0;
      end else if (clken) begin
         r_vld1   <= w_rd;
         r_ok1    <= w_in_rng;
         r_vld2   <= r_vld1;
         r_rdata2 <= w_rdata_s1;
      end
   end

   assign waitrequest   = w_wait;
   assign init_done     = (r_state == ST_READY);
   assign readdata      = (READ_LATENCY == 2) ? r_rdata2 : w_rdata_s1;
   assign readdatavalid = ((READ_LATENCY == 2) ? r_vld2 : r_vld1) & clken;

`ifdef ONCHIP_RAM_PARITY_EN
   logic w_perr_raw, w_perr_s1, r_perr2;

   always_comb begin
      w_perr_raw = 1'b0;
      for (int i = 0; i < BE_WIDTH; i++)
         w_perr_raw = w_perr_raw |
                      (byte_par(w_mem_rdata[i*LANE_W +: 8]) ^ w_mem_rdata[i*LANE_W + 8]);
   end

   assign w_perr_s1 = r_vld1 & r_ok1 & w_perr_raw;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   r_perr2 <= 1'b0;
      else if (clken) r_perr2 <= w_perr_s1;
   end

   assign parity_err = readdatavalid & ((READ_LATENCY == 2) ? r_perr2 : w_perr_s1);
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_onchip_ram_avmm.sv
// Directed bench for onchip_ram_avmm: a DEPTH=16/latency-1 and a DEPTH=12/latency-2 instance share stimulus.
// Honours ONCHIP_RAM_PARITY_EN for the parity-deposit expectations.
module tb_onchip_ram_avmm;

   typedef struct {
      logic [31:0] d;
      logic        pe;
      int          c;
   } resp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  address = '0;
   logic [3:0]  byteenable = '0;
   logic        chipselect = 1'b0, read = 1'b0, write = 1'b0, clken = 1'b1;
   logic [31:0] writedata = '0;

   logic [31:0] rd1, rd2;
   logic        rdv1, rdv2, wr1, wr2, id1, id2, pe1, pe2;

   int    n_chk = 0, n_err = 0, cyc = 0;
   resp_t q1[$], q2[$];

   onchip_ram_avmm #(.DATA_WIDTH(32), .DEPTH(16), .READ_LATENCY(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1),
      .init_done(id1), .parity_err(pe1));

   onchip_ram_avmm #(.DATA_WIDTH(32), .DEPTH(12), .READ_LATENCY(2)) dut2 (
      .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
      .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
      .clken(clken), .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2),
      .init_done(id2), .parity_err(pe2));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rdv1) q1.push_back('{d:rd1, pe:pe1, c:cyc});
      if (rdv2) q2.push_back('{d:rd2, pe:pe2, c:cyc});
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic pop_chk(input string tag, input int which, input logic [31:0] exp_d,
                          input logic exp_pe, input int exp_c);
      resp_t r;
      r = '{d:32'hFFFF_FFFF, pe:1'b1, c:-1};
      if (which == 1) begin
         if (q1.size() > 0) r = q1.pop_front();
      end else begin
         if (q2.size() > 0) r = q2.pop_front();
      end
      chk({tag, " data"}, r.d, exp_d);
      chk({tag, " perr"}, 32'(r.pe), 32'(exp_pe));
      if (exp_c >= 0) chk({tag, " cycle"}, 32'(r.c), 32'(exp_c));
   endtask

   task automatic cmd(input logic r, input logic w, input logic [3:0] a,
                      input logic [3:0] be, input logic [31:0] d);
      chipselect = 1'b1; read = r; write = w; address = a; byteenable = be; writedata = d;
      @(posedge clk); #1;
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rd1"}, rd1, 32'h0);         chk({tag, " rd2"}, rd2, 32'h0);
      chk({tag, " rdv1"}, 32'(rdv1), 32'h0);  chk({tag, " rdv2"}, 32'(rdv2), 32'h0);
      chk({tag, " wait1"}, 32'(wr1), 32'h1);  chk({tag, " wait2"}, 32'(wr2), 32'h1);
      chk({tag, " init1"}, 32'(id1), 32'h0);  chk({tag, " init2"}, 32'(id2), 32'h0);
      chk({tag, " perr1"}, 32'(pe1), 32'h0);  chk({tag, " perr2"}, 32'(pe2), 32'h0);
   endtask

   // Count cycles spent with waitrequest=1 and init_done=0, bounded.
   task automatic count_clear(input string tag);
      int w1 = 0, w2 = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (wr1 && !id1) w1++;
         if (wr2 && !id2) w2++;
         if (id1 && id2) break;
         @(posedge clk); #1;
      end
      chk({tag, " clear cycles1"}, 32'(w1), 32'd16);
      chk({tag, " clear cycles2"}, 32'(w2), 32'd12);
      chk({tag, " ready wait1"}, 32'(wr1), 32'h0);
      @(posedge clk); #1;
   endtask

   logic [31:0] exp3;
   logic        exp3_pe;
   int          c0;

   initial begin
      idle(3);
      chk_reset_vals("reset");

      reset_n = 1'b1;
      count_clear("boot");

      for (int a = 0; a < 16; a++) cmd(1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
      idle(4);
      chk("zero cnt1", 32'(q1.size()), 32'd16);
      chk("zero cnt2", 32'(q2.size()), 32'd16);
      for (int a = 0; a < 16; a++) begin
         pop_chk("zero d1", 1, 32'h0, 1'b0, -1);
         pop_chk("zero d2", 2, 32'h0, 1'b0, -1);
      end

      cmd(1'b0, 1'b1, 4'd5, 4'hF, 32'hDEAD_BEEF);
      cmd(1'b0, 1'b1, 4'd5, 4'h2, 32'h0000_5500);
      cmd(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
      cmd(1'b0, 1'b1, 4'd13, 4'hF, 32'hCAFE_F00D);
      cmd(1'b1, 1'b0, 4'd13, 4'h0, 32'h0);
      idle(4);
      pop_chk("be d1", 1, 32'hDEAD_55EF, 1'b0, -1);
      pop_chk("be d2", 2, 32'hDEAD_55EF, 1'b0, -1);
      pop_chk("oor d1", 1, 32'hCAFE_F00D, 1'b0, -1);
      pop_chk("oor d2", 2, 32'h0, 1'b0, -1);

      cmd(1'b1, 1'b1, 4'd6, 4'hF, 32'h1234_5678);
      idle(4);
      chk("rw drop cnt1", 32'(q1.size()), 32'd0);
      chk("rw drop cnt2", 32'(q2.size()), 32'd0);
      cmd(1'b1, 1'b0, 4'd6, 4'h0, 32'h0);
      idle(4);
      pop_chk("rw d1", 1, 32'h1234_5678, 1'b0, -1);
      pop_chk("rw d2", 2, 32'h1234_5678, 1'b0, -1);

      for (int a = 0; a < 4; a++) cmd(1'b0, 1'b1, 4'(a), 4'hF, 32'h1111_1111 * 32'(a + 1));
      c0 = cyc;
      for (int a = 0; a < 4; a++) cmd(1'b1, 1'b0, 4'(a), 4'h0, 32'h0);
      idle(5);
      for (int a = 0; a < 4; a++) begin
         pop_chk("lat1", 1, 32'h1111_1111 * 32'(a + 1), 1'b0, c0 + 1 + a);
         pop_chk("lat2", 2, 32'h1111_1111 * 32'(a + 1), 1'b0, c0 + 2 + a);
      end

      cmd(1'b1, 1'b0, 4'd0, 4'h0, 32'h0);
      cmd(1'b1, 1'b0, 4'd1, 4'h0, 32'h0);
      clken = 1'b0; chipselect = 1'b1; read = 1'b1; address = 4'd2;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall wait1", 32'(wr1), 32'h1);  chk("stall wait2", 32'(wr2), 32'h1);
         chk("stall rdv1", 32'(rdv1), 32'h0);  chk("stall rdv2", 32'(rdv2), 32'h0);
         @(posedge clk); #1;
      end
      clken = 1'b1; chipselect = 1'b0; read = 1'b0;
      idle(5);
      chk("stall cnt1", 32'(q1.size()), 32'd2);
      chk("stall cnt2", 32'(q2.size()), 32'd2);
      pop_chk("stall a1", 1, 32'h1111_1111, 1'b0, -1);
      pop_chk("stall b1", 1, 32'h2222_2222, 1'b0, -1);
      pop_chk("stall a2", 2, 32'h1111_1111, 1'b0, -1);
      pop_chk("stall b2", 2, 32'h2222_2222, 1'b0, -1);

      dut1.u_array.r_mem[3][17] = ~dut1.u_array.r_mem[3][17];
      dut2.u_array.r_mem[3][17] = ~dut2.u_array.r_mem[3][17];
`ifdef ONCHIP_RAM_PARITY_EN
      exp3 = 32'h4444_4444; exp3_pe = 1'b1;
`else
      exp3 = 32'h4446_4444; exp3_pe = 1'b0;
`endif
      cmd(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
      cmd(1'b1, 1'b0, 4'd2, 4'h0, 32'h0);
      idle(4);
      pop_chk("par bad1", 1, exp3, exp3_pe, -1);
      pop_chk("par ok1", 1, 32'h3333_3333, 1'b0, -1);
      pop_chk("par bad2", 2, exp3, exp3_pe, -1);
      pop_chk("par ok2", 2, 32'h3333_3333, 1'b0, -1);

      cmd(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
      reset_n = 1'b0;
      idle(2);
      chk_reset_vals("flush");
      chk("flush cnt1", 32'(q1.size()), 32'd0);
      chk("flush cnt2", 32'(q2.size()), 32'd0);
      reset_n = 1'b1;
      idle(7);
      chk("midclr init1", 32'(id1), 32'h0);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("midclr");
      @(posedge clk); #1;
      reset_n = 1'b1;
      count_clear("reclear");
      cmd(1'b1, 1'b0, 4'd5, 4'h0, 32'h0);
      cmd(1'b1, 1'b0, 4'd3, 4'h0, 32'h0);
      idle(4);
      pop_chk("reclr5 d1", 1, 32'h0, 1'b0, -1);
      pop_chk("reclr3 d1", 1, 32'h0, 1'b0, -1);
      pop_chk("reclr5 d2", 2, 32'h0, 1'b0, -1);
      pop_chk("reclr3 d2", 2, 32'h0, 1'b0, -1);
      chk("end cnt1", 32'(q1.size()), 32'd0);
      chk("end cnt2", 32'(q2.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
